// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: channel state and mode encodings shared by tick_gen_multi and tick_channel.
package tick_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one independent tick channel counting base strobes up to a latched period.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int PW = 16
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          stb_i,
    input  logic          pre_i,
    input  logic          en_i,
    input  logic          mode_i,
    input  logic          start_i,
    input  logic [PW-1:0] period_i,
    output logic          tick_o,
    output logic          busy_o
);

    ch_state_e     state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d, per_q, per_d;
    logic          mode_q, mode_d, tick_q, tick_d, acc;

    assign acc = start_i && (period_i != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        mode_d  = mode_q;
        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (acc) begin
            state_d = RUN;
            cnt_d   = '0;
            per_d   = period_i;
            mode_d  = mode_i;
        end else if (tick_q) begin
            cnt_d   = '0;
            state_d = (mode_q == MODE_ONESHOT) ? IDLE : RUN;
        end else if (state_q == RUN && stb_i) begin
            cnt_d   = cnt_q + PW'(1);
        end
    end

    // Terminal count is resolved in the cycle before base_stb, so tick_q lines up with base_stb.
    assign tick_d = pre_i && (state_d == RUN) && (cnt_d == per_d - PW'(1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            mode_q  <= MODE_PERIODIC;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
        end
    end

    // A same-cycle disable or accepted restart cancels the pending tick.
    assign tick_o = tick_q && en_i && !acc;
    assign busy_o = (state_q == RUN);

endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: free-running base-strobe prescaler driving NCH independent tick channels.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int BASE_HZ = 1000,
    parameter int NCH     = 4,
    parameter int PW      = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [NCH-1:0]    en,
    input  logic [NCH-1:0]    mode,
    input  logic [NCH-1:0]    start,
    input  logic [NCH*PW-1:0] period,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    busy,
    output logic              base_stb
);

    localparam int PRESC = CLK_HZ / BASE_HZ;
    localparam int CW    = $clog2(PRESC);

    logic [CW-1:0] presc_q, presc_d;
    logic          pre_stb;

    assign base_stb = (presc_q == CW'(PRESC - 1));
    assign pre_stb  = (presc_q == CW'(PRESC - 2));
    assign presc_d  = base_stb ? '0 : presc_q + CW'(1);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_channel #(.PW(PW)) u_ch (
            .CLK      (CLK),
            .RSTn     (RSTn),
            .stb_i    (base_stb),
            .pre_i    (pre_stb),
            .en_i     (en[i]),
            .mode_i   (mode[i]),
            .start_i  (start[i]),
            .period_i (period[i*PW +: PW]),
            .tick_o   (tick[i]),
            .busy_o   (busy[i])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed bench with a countdown reference model checked every cycle.
module tb_tick_gen_multi;

    localparam int NCH   = 4;
    localparam int PW    = 16;
    localparam int PRESC = 10;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic [NCH-1:0]    en, mode, start, tick, busy;
    logic [NCH*PW-1:0] period;
    logic              base_stb;

    int checks = 0, errors = 0, cyc = 0, stb_cnt = 0;
    int tick_cnt[NCH] = '{default: 0};
    int busy_cyc[NCH] = '{default: 0};

    int ph = 0;
    bit m_run[NCH] = '{default: 0};
    bit m_one[NCH] = '{default: 0};
    int m_rem[NCH] = '{default: 0};
    int m_per[NCH] = '{default: 0};

    tick_gen_multi #(.CLK_HZ(1000), .BASE_HZ(100), .NCH(NCH), .PW(PW)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .en       (en),
        .mode     (mode),
        .start    (start),
        .period   (period),
        .tick     (tick),
        .busy     (busy),
        .base_stb (base_stb)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int per_in(input int ch);
        return int'(period[ch*PW +: PW]);
    endfunction

    function automatic int sum_ticks();
        int s = 0;
        for (int i = 0; i < NCH; i++) s += tick_cnt[i];
        return s;
    endfunction

    // Model: each running channel counts down the base strobes left before its next tick.
    always @(negedge CLK) begin
        logic           exp_stb;
        logic [NCH-1:0] et, eb;
        bit             acc;
        if (!RSTn) begin
            ph = 0;
            for (int i = 0; i < NCH; i++) m_run[i] = 0;
        end
        exp_stb = (ph == PRESC - 1);
        for (int i = 0; i < NCH; i++) begin
            acc   = start[i] && per_in(i) != 0;
            et[i] = en[i] && m_run[i] && exp_stb && m_rem[i] == 1 && !acc;
            eb[i] = m_run[i];
        end
        chk("base_stb", base_stb, exp_stb);
        chk("tick", tick, et);
        chk("busy", busy, eb);
        stb_cnt += base_stb;
        for (int i = 0; i < NCH; i++) begin
            tick_cnt[i] += tick[i];
            busy_cyc[i] += busy[i];
        end
        if (RSTn) begin
            ph = (ph + 1) % PRESC;
            for (int i = 0; i < NCH; i++) begin
                acc = start[i] && per_in(i) != 0;
                if (!en[i]) m_run[i] = 0;
                else if (acc) begin
                    m_run[i] = 1;
                    m_per[i] = per_in(i);
                    m_one[i] = mode[i];
                    m_rem[i] = per_in(i);
                end else if (m_run[i] && exp_stb) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_rem[i] = m_per[i];
                        if (m_one[i]) m_run[i] = 0;
                    end
                end
            end
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic m, input int p);
        mode[ch] = m;
        period[ch*PW +: PW] = PW'(p);
    endtask

    task automatic pulse_start(input logic [NCH-1:0] s);
        start = s;
        cyc_wait(1);
        start = '0;
    endtask

    task automatic wait_tick(input int ch, input int budget, output int t);
        int n = 0;
        t = -1;
        while (n < budget && t < 0) begin
            @(negedge CLK);
            n++;
            if (tick[ch]) t = cyc;
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_tick ch%0d: got=no tick exp=tick within %0d cycles", ch, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int s0, n0, ts, t1, t2, tr;
        RSTn = 1'b0; en = '0; mode = '0; start = '0; period = '0;
        cyc_wait(3);
        RSTn = 1'b1;

        s0 = stb_cnt;
        cyc_wait(1000);
        chk("idle_stb_count", stb_cnt - s0, 100);
        chk("idle_ticks", sum_ticks(), 0);
        chk("idle_busy_cycles", busy_cyc[0] + busy_cyc[1] + busy_cyc[2] + busy_cyc[3], 0);

        en = '1;
        set_ch(0, 1'b0, 3);
        ts = cyc;
        pulse_start(4'b0001);
        wait_tick(0, 40, t1);
        chk("ch0_first_latency_in_21_30", (t1 - ts >= 21 && t1 - ts <= 30), 1);
        wait_tick(0, 40, t2);
        chk("ch0_period", t2 - t1, 30);
        chk("ch0_busy", busy[0], 1);

        cyc_wait(1);
        set_ch(1, 1'b1, 5);
        pulse_start(4'b0010);
        wait_tick(1, 60, t1);
        @(negedge CLK);
        chk("ch1_busy_after_tick", busy[1], 0);
        n0 = tick_cnt[1];
        cyc_wait(200);
        chk("ch1_no_more_ticks", tick_cnt[1] - n0, 0);

        set_ch(2, 1'b0, 4);
        pulse_start(4'b0100);
        wait_tick(2, 50, t1);
        repeat (40) @(posedge CLK);
        #1 start = 4'b0100;
        @(negedge CLK);
        chk("ch2_restart_on_stb", base_stb, 1);
        chk("ch2_restart_no_tick", tick[2], 0);
        tr = cyc;
        cyc_wait(1);
        start = '0;
        wait_tick(2, 50, t2);
        chk("ch2_tick_after_restart", t2 - tr, 40);

        cyc_wait(1);
        set_ch(3, 1'b0, 0);
        pulse_start(4'b1000);
        s0 = busy_cyc[3];
        cyc_wait(50);
        chk("ch3_zero_period_busy", busy_cyc[3] - s0, 0);
        set_ch(3, 1'b0, 7);
        pulse_start(4'b1000);
        wait_tick(3, 80, t1);
        chk("ch3_busy", busy[3], 1);
        repeat (70) @(posedge CLK);
        #1 en[3] = 1'b0;
        @(negedge CLK);
        chk("ch3_en_drop_on_stb", base_stb, 1);
        chk("ch3_en_drop_no_tick", tick[3], 0);
        @(negedge CLK);
        chk("ch3_idle_after_en_drop", busy[3], 0);

        cyc_wait(1);
        en = '1;
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 2);
        pulse_start('1);
        wait_tick(0, 30, t1);
        chk("all_simultaneous", tick, 4'hF);
        repeat (20) @(negedge CLK);
        chk("all_simultaneous_again", tick, 4'hF);

        cyc_wait(3);
        RSTn = 1'b0;
        @(negedge CLK);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_base_stb", base_stb, 0);
        cyc_wait(3);
        RSTn = 1'b1;
        n0 = sum_ticks();
        cyc_wait(100);
        chk("post_rst_ticks", sum_ticks() - n0, 0);
        chk("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_gen_multi.md
TICK_GEN_MULTI -- requirements
Module: tick_gen_multi

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL provide parameter BASE_HZ, default 1000, base strobe rate in Hz; PRESC = CLK_HZ/BASE_HZ, integer, at least 2.
REQ-003 SHALL provide parameter NCH, default 4, number of independent tick channels.
REQ-004 SHALL provide parameter PW, default 16, per-channel period width in bits.
REQ-005 CLK  input  1  system clock, rising edge.
REQ-006 RSTn  input  1  reset, asynchronous, active-low.
REQ-007 en  input  NCH  per-channel enable; low forces the channel idle.
REQ-008 mode  input  NCH  per-channel mode: 0 = periodic, 1 = one-shot.
REQ-009 start  input  NCH  per-channel single-cycle start/restart strobe.
REQ-010 period  input  NCH*PW  per-channel period in base strobes; channel i occupies bits [i*PW +: PW].
REQ-011 tick  output  NCH  per-channel single-CLK-cycle tick pulse.
REQ-012 busy  output  NCH  per-channel high while the channel is in RUN.
REQ-013 base_stb  output  1  free-running base strobe, one CLK cycle wide.

Function
REQ-014 Prescaler SHALL count 0..PRESC-1, wrap to 0, and assert base_stb in the cycle its count equals PRESC-1; it runs regardless of channel state.
REQ-015 Each channel SHALL have states IDLE and RUN, plus a PW-bit strobe counter and a latched period register.
REQ-016 IDLE->RUN: on start=1, en=1 and period!=0, the channel SHALL latch period and mode, clear its counter, and assert busy from the next cycle.
REQ-017 start with period==0, or start with en=0, SHALL be ignored; the channel stays IDLE.
REQ-018 In RUN, each base_stb SHALL increment the counter; on the base_stb where counter == latched period-1, tick SHALL be asserted in that same cycle (registered output, one cycle wide).
REQ-019 Periodic mode at terminal count: counter clears and the channel stays in RUN, so ticks recur every latched period base strobes.
REQ-020 One-shot mode at terminal count: tick fires once, the channel returns to IDLE, and busy deasserts in the cycle after tick.
REQ-021 First tick after start SHALL occur after latched period base strobes; phase jitter against start is 0..PRESC-1 CLK cycles (free-running prescaler).
REQ-022 start while in RUN SHALL restart the channel: relatch period and mode, clear the counter, and emit no tick that cycle; start wins over a coincident terminal count.
REQ-023 Changes to period or mode inputs while in RUN SHALL have no effect until the next start.
REQ-024 en low in any state SHALL force IDLE, clear the counter, and suppress tick in that same cycle; en low overrides start.
REQ-025 Counter arithmetic SHALL be PW bits, unsigned; period = 2^PW-1 SHALL work without overflow.
REQ-026 Channels SHALL be fully independent; simultaneous ticks on all channels are allowed.

Reset
REQ-027 While RSTn is low: prescaler count=0, all channels IDLE with counters and latches 0, tick=0, busy=0, base_stb=0.
REQ-028 Reset assertion mid-count SHALL abort all channels immediately, with no tick in the reset cycle or after release until a new start.

Structure
REQ-029 Shared package tick_gen_pkg SHALL hold the channel state enum (IDLE, RUN) and the mode constants MODE_PERIODIC=0 and MODE_ONESHOT=1.
REQ-030 Per-channel logic SHALL be a sub-module tick_channel (parameter PW), instantiated NCH times via generate; the prescaler stays in the top level.

Verification (CLK_HZ=1000, BASE_HZ=100, so PRESC=10; NCH=4, PW=16)
REQ-031 Reset release, no start -> base_stb every 10 cycles; tick=0 and busy=0 for 1000 cycles.
REQ-032 ch0 periodic, period=3, start -> ticks exactly 30 CLK apart, each 1 cycle wide; busy stays high.
REQ-033 ch1 one-shot, period=5, start -> exactly one tick, then busy=0 the next cycle, and no further ticks for 200 cycles.
REQ-034 ch2 periodic, period=4, restart start coincident with terminal base_stb -> no tick that cycle; next tick 40 CLK later.
REQ-035 ch3 period=0 start -> busy stays 0; separately, en dropped mid-RUN -> busy=0 next cycle, no tick.
REQ-036 All four channels started same cycle with period=2 -> simultaneous ticks every 20 CLK; RSTn pulse mid-run -> all outputs 0 and no ticks after release.
